// File: rtl/key_debounce_pkg.sv
// Shared definitions for the per-key debouncer: FSM state codes exported on
// the debug header, so they must stay fixed at these encodings.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  // Debounced level implied by a state: the key counts as down until a
  // release has been fully confirmed.
  function automatic logic level_of(input state_t s);
    logic lvl;
    case (s)
      HELD, RELEASE_WAIT: lvl = 1'b1;
      default:            lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: accepts a new KeyIn level only after it has held for
// STABLE_CYCLES further edges, then emits a clean level and one-cycle pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       KeyIn,
  output logic       KeyLevel,
  output logic       KeyPress,
  output logic       KeyRelease,
  output logic [1:0] State
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] count_r;

  assign State = state_r;

  // Debounce FSM with inline qualification counter; all outputs registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      count_r    <= '0;
      KeyLevel   <= 1'b0;
      KeyPress   <= 1'b0;
      KeyRelease <= 1'b0;
    end else begin
      KeyPress   <= 1'b0;
      KeyRelease <= 1'b0;
      case (state_r)
        IDLE: begin
          if (KeyIn) begin
            state_r <= PRESS_WAIT;
            count_r <= '0;
          end else begin
            state_r <= IDLE;
          end
          KeyLevel <= level_of(IDLE);
        end
        PRESS_WAIT: begin
          if (!KeyIn) begin
            state_r  <= IDLE;
            count_r  <= '0;
            KeyLevel <= level_of(IDLE);
          end else if (count_r == LAST) begin
            // Press confirmed: level and pulse change on the same edge.
            state_r  <= HELD;
            count_r  <= '0;
            KeyLevel <= level_of(HELD);
            KeyPress <= 1'b1;
          end else begin
            count_r  <= count_r + CNT_W'(1);
            KeyLevel <= level_of(PRESS_WAIT);
          end
        end
        HELD: begin
          if (!KeyIn) begin
            state_r <= RELEASE_WAIT;
            count_r <= '0;
          end else begin
            state_r <= HELD;
          end
          KeyLevel <= level_of(HELD);
        end
        RELEASE_WAIT: begin
          if (KeyIn) begin
            state_r  <= HELD;
            count_r  <= '0;
            KeyLevel <= level_of(HELD);
          end else if (count_r == LAST) begin
            state_r    <= IDLE;
            count_r    <= '0;
            KeyLevel   <= level_of(IDLE);
            KeyRelease <= 1'b1;
          end else begin
            count_r  <= count_r + CNT_W'(1);
            KeyLevel <= level_of(RELEASE_WAIT);
          end
        end
        default: begin
          state_r  <= IDLE;
          count_r  <= '0;
          KeyLevel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (STABLE_CYCLES=4): a run-length model
// of the debounce rule is compared every cycle, plus literal checkpoints.
module tb_key_debounce;

  localparam int S = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       KeyIn = 1'b0;
  logic       KeyLevel;
  logic       KeyPress;
  logic       KeyRelease;
  logic [1:0] State;

  key_debounce #(.STABLE_CYCLES(S)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .KeyIn      (KeyIn),
    .KeyLevel   (KeyLevel),
    .KeyPress   (KeyPress),
    .KeyRelease (KeyRelease),
    .State      (State)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passed = 0;
  int n_press = 0;
  int n_release = 0;

  // Model: accepted level plus length of the current run of samples that
  // disagree with it; S+1 consecutive disagreeing samples flip the level.
  int m_lvl = 0;
  int m_run = 0;
  int m_press = 0;
  int m_rel = 0;

  function automatic int m_state();
    if (m_lvl == 1) return (m_run > 0) ? 3 : 2;
    else            return (m_run > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_run = 0; m_press = 0; m_rel = 0;
  endtask

  task automatic model_edge(input int k);
    m_press = 0;
    m_rel = 0;
    if (k != m_lvl) begin
      m_run = m_run + 1;
      if (m_run == S + 1) begin
        m_lvl = k;
        m_run = 0;
        if (k == 1) m_press = 1;
        else        m_rel = 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("state", int'(State), m_state());
    check("level", int'(KeyLevel), m_lvl);
    check("press", int'(KeyPress), m_press);
    check("release", int'(KeyRelease), m_rel);
    check("pulse_exclusive", int'(KeyPress & KeyRelease), 0);
    n_press = n_press + int'(KeyPress);
    n_release = n_release + int'(KeyRelease);
  endtask

  // Drive one sample, let the edge happen, advance the model, compare mid-cycle.
  task automatic step(input int k);
    KeyIn = (k != 0);
    @(posedge Clk);
    model_edge(k);
    @(negedge Clk);
    compare_all();
  endtask

  // Literal checkpoint pinning both the DUT and the model to a hand value.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    check({name, "_dut"}, dut_v, exp);
    check({name, "_model"}, mdl_v, exp);
  endtask

  initial begin
    // Reset state, held with no clock edge needed.
    #2;
    check("reset_state", int'(State), 0);
    check("reset_level", int'(KeyLevel), 0);
    check("reset_pulses", int'(KeyPress | KeyRelease), 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    step(0);
    step(0);

    // Clean press held for 20 cycles.
    n_press = 0;
    step(1);
    lit("clean_e0_state", int'(State), m_state(), 1);
    for (int i = 1; i < 20; i++) begin
      step(1);
      if (i == 4) begin
        lit("clean_e4_state", int'(State), m_state(), 2);
        lit("clean_e4_press", int'(KeyPress), m_press, 1);
        lit("clean_e4_level", int'(KeyLevel), m_lvl, 1);
      end else if (i == 5) begin
        lit("clean_e5_press", int'(KeyPress), m_press, 0);
      end else begin
      end
    end
    check("clean_press_count", n_press, 1);

    // Release glitch: one low sample then high again.
    step(0);
    lit("glitch_state_rw", int'(State), m_state(), 3);
    lit("glitch_level_rw", int'(KeyLevel), m_lvl, 1);
    step(1);
    lit("glitch_state_held", int'(State), m_state(), 2);
    lit("glitch_level_held", int'(KeyLevel), m_lvl, 1);

    // Clean release.
    n_release = 0;
    for (int i = 0; i < 7; i++) begin
      step(0);
      if (i == 4) begin
        lit("release_e4_level", int'(KeyLevel), m_lvl, 0);
        lit("release_e4_pulse", int'(KeyRelease), m_rel, 1);
        lit("release_e4_state", int'(State), m_state(), 0);
      end else if (i == 5) begin
        lit("release_e5_pulse", int'(KeyRelease), m_rel, 0);
      end else begin
      end
    end
    check("clean_release_count", n_release, 1);

    // Press bounce: 1,1,0,1,1,1,1,1.
    n_press = 0;
    step(1);
    step(1);
    step(0);
    lit("bounce_e2_state", int'(State), m_state(), 0);
    step(1);
    lit("bounce_e3_state", int'(State), m_state(), 1);
    step(1);
    step(1);
    step(1);
    lit("bounce_e6_press", int'(KeyPress), m_press, 0);
    step(1);
    lit("bounce_e7_press", int'(KeyPress), m_press, 1);
    check("bounce_press_count", n_press, 1);
    for (int i = 0; i < 6; i++) step(0);

    // Async reset while PRESS_WAIT with Count=2, key still held.
    step(1);
    step(1);
    step(1);
    lit("pre_reset_state", int'(State), m_state(), 1);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_state", int'(State), 0);
    check("async_reset_outputs", int'({KeyLevel, KeyPress, KeyRelease}), 0);
    #1 Reset = 1'b0;
    n_press = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (i == 4) lit("after_reset_press", int'(KeyPress), m_press, 1);
      else if (i == 3) lit("after_reset_nopress", int'(KeyPress), m_press, 0);
      else begin end
    end
    check("after_reset_press_count", n_press, 1);

    // Async reset from HELD drops the level immediately.
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check("held_reset_level", int'(KeyLevel), 0);
    check("held_reset_state", int'(State), 0);
    #1 Reset = 1'b0;
    for (int i = 0; i < 8; i++) step(0);

    // Long hold: exactly one press, release only after 5 low edges.
    n_press = 0;
    n_release = 0;
    for (int i = 0; i < 1000; i++) step(1);
    check("long_press_count", n_press, 1);
    check("long_release_none", n_release, 0);
    for (int i = 0; i < 4; i++) step(0);
    check("long_release_early", n_release, 0);
    step(0);
    lit("long_release_e4", int'(KeyRelease), m_rel, 1);
    step(0);
    check("long_release_count", n_release, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
